pwm_multi: RTL and testbench

Parametrised multi-channel PWM generator for DAC and LED-drive outputs. All channels share one prescaled time base. Each channel has a duty shadow register that transfers to its active register only at a period boundary, so duty changes never glitch mid-period. Edge-aligned by default; center-aligned counting is a build option.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_timebase.sv | 86 ++++++++
 rtl/pwm_multi.sv | 80 ++++++++
 tb/tb_pwm_multi.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the multi-channel PWM generator.
// Imported by pwm_timebase and pwm_multi.
package pwm_pkg;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // Largest duty/count code for a given counter width.
   function automatic int unsigned pwm_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

   function automatic int unsigned chan_idx_w(input int unsigned channels);
      return (channels <= 1) ? 1 : $clog2(channels);
   endfunction

   function automatic int unsigned presc_w(input int unsigned prescale);
      return (prescale <= 1) ? 1 : $clog2(prescale);
   endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM time base: prescaler, up or triangular counter, boundary strobe.
// Build option PWM_CENTER_ALIGN_EN selects the triangular (center-aligned) count.
module pwm_timebase
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable_i,
   output logic [WIDTH-1:0] count_o,
   output logic             boundary_o,
   output logic             running_o,
   output logic             period_start_o
);

   localparam int unsigned      PW       = presc_w(PRESCALE);
   localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(pwm_max(WIDTH));
   localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0]    pre_q;
   logic [WIDTH-1:0] count_q;
   dir_e             dir_q;
   logic             run_q;
   logic             period_start_q;
   logic             tick;
   logic             wrap;
   logic             boundary;

   always_comb begin
      tick = run_q && (pre_q == PRE_LAST);
`ifdef PWM_CENTER_ALIGN_EN
      wrap = (dir_q == DIR_DOWN) && (count_q == WIDTH'(1));
`else
      wrap = (count_q == MAX_C);
`endif
      // The first enabled edge after idle is itself a period boundary.
      boundary = enable_i && (!run_q || (tick && wrap));
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge value of every other flop regardless of code order.
   always_ff @(posedge clk) begin
      if (!rst_n || !enable_i) begin
         pre_q          <= '0;
         count_q        <= '0;
         dir_q          <= DIR_UP;
         run_q          <= 1'b0;
         period_start_q <= 1'b0;
      end else begin
         run_q          <= 1'b1;
         period_start_q <= boundary;
         if (!run_q) begin
            pre_q   <= '0;
            count_q <= '0;
            dir_q   <= DIR_UP;
         end else if (tick) begin
            pre_q <= '0;
`ifdef PWM_CENTER_ALIGN_EN
            if (dir_q == DIR_UP) begin
               if (count_q == MAX_C) begin
                  count_q <= MAX_C - 1'b1;
                  dir_q   <= DIR_DOWN;
               end else begin
                  count_q <= count_q + 1'b1;
               end
            end else begin
               count_q <= count_q - 1'b1;
               if (count_q == WIDTH'(1)) dir_q <= DIR_UP;
            end
`else
            count_q <= count_q + 1'b1;
`endif
         end else begin
            pre_q <= pre_q + 1'b1;
         end
      end
   end

   assign count_o        = count_q;
   assign boundary_o     = boundary;
   assign running_o      = enable_i && run_q;
   assign period_start_o = period_start_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared time base plus per-channel shadow/active duty and compare.
// Build option PWM_CENTER_ALIGN_EN (handled in pwm_timebase) gives center-aligned output.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned WIDTH    = 10,
   parameter int unsigned CHANNELS = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                enable,
   input  logic                                load,
   input  logic [chan_idx_w(CHANNELS)-1:0]     ch_sel,
   input  logic [WIDTH-1:0]                    data_in,
   output logic [CHANNELS-1:0]                 pwm_out,
   output logic                                period_start
);

   typedef logic [WIDTH-1:0] duty_t;

   localparam int unsigned CW    = chan_idx_w(CHANNELS);
   localparam duty_t       MAX_C = duty_t'(pwm_max(WIDTH));

   duty_t               shadow_q [CHANNELS];
   duty_t               shadow_d [CHANNELS];
   duty_t               active_q [CHANNELS];
   duty_t               active_d [CHANNELS];
   logic [CHANNELS-1:0] pwm_q;
   logic [CHANNELS-1:0] pwm_d;
   duty_t               count;
   logic                boundary;
   logic                running;

   pwm_timebase #(
      .WIDTH    (WIDTH),
      .PRESCALE (PRESCALE)
   ) u_timebase (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable_i       (enable),
      .count_o        (count),
      .boundary_o     (boundary),
      .running_o      (running),
      .period_start_o (period_start)
   );

   // NOTE: every next-state variable takes a full default before the loop so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pwm_d    = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         // Out-of-range ch_sel matches no channel, so the write is dropped.
         if (load && (ch_sel == CW'(i))) shadow_d[i] = data_in;
         if (boundary) active_d[i] = shadow_q[i];
         pwm_d[i] = running && ((active_q[i] == MAX_C) || (count < active_q[i]));
      end
   end

   // NOTE: the duty arrays are plain flops, not RAM, so they take the reset
   // along with the rest of the state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         pwm_q <= '0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: two instances (PRESCALE 1 and 3) against a
// period-arithmetic reference model, plus directed period/duty measurements.
module tb_pwm_multi;

   localparam int MAXV = 15;
`ifdef PWM_CENTER_ALIGN_EN
   localparam bit CENTER = 1'b1;
`else
   localparam bit CENTER = 1'b0;
`endif
   localparam int PER_A = CENTER ? 2 * MAXV : MAXV + 1;
   localparam int PER_B = 3 * PER_A;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       load;
   logic [1:0] ch_sel;
   logic [3:0] data_in;
   logic [1:0] pwm_a;
   logic [2:0] pwm_b;
   logic       ps_a;
   logic       ps_b;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pwm_multi #(.WIDTH(4), .CHANNELS(2), .PRESCALE(1)) dut_a (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .load         (load),
      .ch_sel       (ch_sel[0:0]),
      .data_in      (data_in),
      .pwm_out      (pwm_a),
      .period_start (ps_a)
   );

   pwm_multi #(.WIDTH(4), .CHANNELS(3), .PRESCALE(3)) dut_b (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .load         (load),
      .ch_sel       (ch_sel),
      .data_in      (data_in),
      .pwm_out      (pwm_b),
      .period_start (ps_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int p_of(input int u);
      return (u == 0) ? 1 : 3;
   endfunction

   function automatic int n_of(input int u);
      return (u == 0) ? 2 : 3;
   endfunction

   function automatic int per_of(input int p);
      return CENTER ? 2 * MAXV * p : (MAXV + 1) * p;
   endfunction

   // Counter value t clocks into a period.
   function automatic int cnt_of(input int t, input int p);
      int k;
      k = t / p;
      if (CENTER && k > MAXV) return 2 * MAXV - k;
      return k;
   endfunction

   // High clocks per period for a steady duty d.
   function automatic int exp_hi(input int d, input int p);
      if (d == 0) return 0;
      if (d == MAXV) return per_of(p);
      return CENTER ? (2 * d - 1) * p : d * p;
   endfunction

   bit         m_run [2];
   int         m_t   [2];
   int         m_sh  [2][3];
   int         m_act [2][3];
   logic [2:0] m_pwm [2];
   logic       m_ps  [2];

   task automatic model_step(input int u);
      int cnow;
      int sel;
      int nsh [3];
      if (!rst_n) begin
         m_run[u] = 1'b0;
         m_t[u]   = 0;
         m_ps[u]  = 1'b0;
         m_pwm[u] = '0;
         for (int c = 0; c < 3; c++) begin
            m_sh[u][c]  = 0;
            m_act[u][c] = 0;
         end
         return;
      end
      cnow     = cnt_of(m_t[u], p_of(u));
      m_pwm[u] = '0;
      if (enable && m_run[u])
         for (int c = 0; c < n_of(u); c++)
            m_pwm[u][c] = (m_act[u][c] == MAXV) || (cnow < m_act[u][c]);
      for (int c = 0; c < 3; c++) nsh[c] = m_sh[u][c];
      sel = (u == 0) ? int'(ch_sel[0]) : int'(ch_sel);
      if (load && sel < n_of(u)) nsh[sel] = int'(data_in);
      if (!enable) begin
         m_run[u] = 1'b0;
         m_t[u]   = 0;
         m_ps[u]  = 1'b0;
      end else if (!m_run[u]) begin
         m_run[u] = 1'b1;
         m_t[u]   = 0;
         m_ps[u]  = 1'b1;
         for (int c = 0; c < 3; c++) m_act[u][c] = m_sh[u][c];
      end else begin
         m_t[u]  = m_t[u] + 1;
         m_ps[u] = 1'b0;
         if (m_t[u] == per_of(p_of(u))) begin
            m_t[u]  = 0;
            m_ps[u] = 1'b1;
            for (int c = 0; c < 3; c++) m_act[u][c] = m_sh[u][c];
         end
      end
      for (int c = 0; c < 3; c++) m_sh[u][c] = nsh[c];
   endtask

   initial begin
      m_pwm[0] = '0; m_pwm[1] = '0; m_ps[0] = 1'b0; m_ps[1] = 1'b0;
      forever begin
         @(posedge clk);
         model_step(0);
         model_step(1);
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check("pwm_a", pwm_a, m_pwm[0][1:0]);
         check("pwm_b", pwm_b, m_pwm[1]);
         check("ps_a", ps_a, m_ps[0]);
         check("ps_b", ps_b, m_ps[1]);
      end
   end

   // ---------------- directed helpers ----------------
   function automatic logic ps_of(input int u);
      return (u == 0) ? ps_a : ps_b;
   endfunction

   function automatic logic pwm_of(input int u, input int c);
      return (u == 0) ? pwm_a[c] : pwm_b[c];
   endfunction

   task automatic do_load(input int ch, input int val);
      @(negedge clk);
      load    = 1'b1;
      ch_sel  = 2'(ch);
      data_in = 4'(val);
      @(negedge clk);
      load = 1'b0;
   endtask

   // Measures one full period of channel c on instance u, starting at a period_start.
   task automatic measure(input int u, input int c, input bit at_ps,
                          output int per, output int hi, output int first);
      bit got;
      int n;
      per = 0; hi = 0; first = -1; got = 1'b0; n = 0;
      if (!at_ps) begin
         for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (ps_of(u)) got = 1'b1;
         end
         if (!got) begin
            check("wait_ps_timeout", 0, 1);
            return;
         end
         got = 1'b0;
      end
      while (!got && n < 400) begin
         @(negedge clk);
         n++;
         if (pwm_of(u, c)) begin
            hi++;
            if (first < 0) first = n;
         end
         if (ps_of(u)) got = 1'b1;
      end
      per = n;
      if (!got) check("period_timeout", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int per, hi, first, en_hold;
      en_hold = 0;
      rst_n = 1'b0; enable = 1'b1; load = 1'b1; ch_sel = 2'd0; data_in = 4'd9;
      repeat (3) @(negedge clk);
      check("rst_pwm_a", pwm_a, 0);
      check("rst_pwm_b", pwm_b, 0);
      check("rst_ps_a", ps_a, 0);
      rst_n = 1'b1;
      load  = 1'b0;
      @(negedge clk);
      check("first_ps_a", ps_a, 1);
      check("first_ps_b", ps_b, 1);
      measure(0, 0, 1'b1, per, hi, first);
      check("rst_period_a", per, PER_A);
      check("rst_hi_a", hi, 0);

      do_load(0, 5);
      check("load_midperiod_a", pwm_a[0], 0);
      measure(0, 0, 1'b0, per, hi, first);
      check("d5_period_a", per, PER_A);
      check("d5_hi_a", hi, exp_hi(5, 1));
      check("d5_first_a", first, 1);

      do_load(0, 0);
      do_load(1, 15);
      measure(0, 0, 1'b0, per, hi, first);
      check("d0_hi_a", hi, 0);
      measure(0, 1, 1'b1, per, hi, first);
      check("dmax_hi_a", hi, PER_A);

      // Load ch1=8 on the edge where the count returns to 0.
      repeat (PER_A - 1) @(negedge clk);
      load = 1'b1; ch_sel = 2'd1; data_in = 4'd8;
      @(negedge clk);
      load = 1'b0;
      check("bnd_ps_a", ps_a, 1);
      measure(0, 1, 1'b1, per, hi, first);
      check("bnd_old_hi_a", hi, exp_hi(15, 1));
      measure(0, 1, 1'b1, per, hi, first);
      check("bnd_new_hi_a", hi, exp_hi(8, 1));

      do_load(3, 7);
      measure(1, 1, 1'b0, per, hi, first);
      check("oor_period_b", per, PER_B);
      check("oor_hi_b", hi, exp_hi(8, 3));

      do_load(0, 4);
      measure(1, 0, 1'b0, per, hi, first);
      check("p3_period_b", per, PER_B);
      check("p3_hi_b", hi, exp_hi(4, 3));
      measure(0, 0, 1'b0, per, hi, first);
      check("d4_period_a", per, PER_A);
      check("d4_hi_a", hi, exp_hi(4, 1));

      repeat (2) @(negedge clk);
      check("pre_drop_a", pwm_a[0], 1);
      enable = 1'b0;
      @(negedge clk);
      check("drop_pwm_a", pwm_a, 0);
      check("drop_pwm_b", pwm_b, 0);
      check("drop_ps_a", ps_a, 0);
      repeat (3) @(negedge clk);
      enable = 1'b1;
      @(negedge clk);
      check("reen_ps_a", ps_a, 1);
      check("reen_ps_b", ps_b, 1);

      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         rst_n = ($urandom_range(0, 399) != 0);
         if (en_hold > 0) begin
            en_hold--;
            enable = 1'b0;
         end else if ($urandom_range(0, 59) == 0) begin
            en_hold = $urandom_range(1, 5);
            enable  = 1'b0;
         end else begin
            enable = 1'b1;
         end
         load   = ($urandom_range(0, 2) == 0);
         ch_sel = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 5))
            0:       data_in = 4'd0;
            1:       data_in = 4'd15;
            default: data_in = 4'($urandom_range(0, 15));
         endcase
      end
      load = 1'b0; enable = 1'b1; rst_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
